// File: rtl/loproc_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package loproc_divider_pkg;

  localparam int unsigned DefaultDataWidth = 32;

  typedef enum logic {
    DivIdle = 1'b0,
    DivBusy = 1'b1
  } div_state_e;

  // Width of the iteration counter; must hold the value DATA_WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/loproc_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract divisor.
module loproc_div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  always_comb begin
    shifted = {rem, dividend_bit};
    trial   = shifted - {1'b0, divisor};
    // Sign bit of the extended difference tells whether the divisor fit.
    q_bit   = ~trial[DATA_WIDTH];
    if (q_bit) begin
      rem_next = trial[DATA_WIDTH-1:0];
    end else begin
      rem_next = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/loproc_divider.sv
// Radix-2 restoring integer divider, signed or unsigned, one quotient bit per cycle.
module loproc_divider
  import loproc_divider_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  div_clk,
  input  logic                  div_rst_n,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic                  is_signed,
  input  logic                  valid_in,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic                  div_by_zero,
  output logic                  valid_out
);

  localparam int unsigned CntW = cnt_width(DATA_WIDTH);

  div_state_e            state_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] dvd_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic                  sq_q;
  logic                  sr_q;

  logic [DATA_WIDTH-1:0] mag1;
  logic [DATA_WIDTH-1:0] mag2;
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_q;
  logic [DATA_WIDTH-1:0] q_shift;

  always_comb begin
    mag1    = (is_signed && in1[DATA_WIDTH-1]) ? -in1 : in1;
    mag2    = (is_signed && in2[DATA_WIDTH-1]) ? -in2 : in2;
    // Dividend register doubles as the quotient accumulator.
    q_shift = {dvd_q[DATA_WIDTH-2:0], step_q};
  end

  loproc_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem         (rem_q),
    .dividend_bit(dvd_q[DATA_WIDTH-1]),
    .divisor     (dvs_q),
    .rem_next    (step_rem),
    .q_bit       (step_q)
  );

  assign ready = (state_q == DivIdle);

  always_ff @(posedge div_clk) begin
    if (!div_rst_n) begin
      state_q     <= DivIdle;
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      out_q       <= '0;
      out_r       <= '0;
      div_by_zero <= 1'b0;
      valid_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state_q)
        DivIdle: begin
          if (valid_in) begin
            if (in2 == '0) begin
              out_q       <= '1;
              out_r       <= in1;
              div_by_zero <= 1'b1;
              valid_out   <= 1'b1;
            end else begin
              sq_q    <= is_signed & (in1[DATA_WIDTH-1] ^ in2[DATA_WIDTH-1]);
              sr_q    <= is_signed & in1[DATA_WIDTH-1];
              dvd_q   <= mag1;
              dvs_q   <= mag2;
              rem_q   <= '0;
              count_q <= CntW'(DATA_WIDTH);
              state_q <= DivBusy;
            end
          end
        end
        DivBusy: begin
          rem_q   <= step_rem;
          dvd_q   <= q_shift;
          count_q <= count_q - 1'b1;
          if (count_q == CntW'(1)) begin
            out_q       <= sq_q ? -q_shift : q_shift;
            out_r       <= sr_q ? -step_rem : step_rem;
            div_by_zero <= 1'b0;
            valid_out   <= 1'b1;
            state_q     <= DivIdle;
          end
        end
        default: state_q <= DivIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_loproc_divider.sv
// Directed self-checking bench for loproc_divider with hand-computed expected results.
module tb_loproc_divider;

  logic        div_clk;
  logic        div_rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        is_signed;
  logic        valid_in;
  logic        ready;
  logic [31:0] out_q;
  logic [31:0] out_r;
  logic        div_by_zero;
  logic        valid_out;

  int checks;
  int errors;

  loproc_divider #(
    .DATA_WIDTH(32)
  ) dut (
    .div_clk    (div_clk),
    .div_rst_n  (div_rst_n),
    .in1        (in1),
    .in2        (in2),
    .is_signed  (is_signed),
    .valid_in   (valid_in),
    .ready      (ready),
    .out_q      (out_q),
    .out_r      (out_r),
    .div_by_zero(div_by_zero),
    .valid_out  (valid_out)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  // Drives operands for one edge; edges counts posedges from the accepting one inclusive
  // until valid_out is seen (bounded), ready_low counts samples with ready low.
  task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output int edges, output int ready_low);
    in1 = a;
    in2 = b;
    is_signed = s;
    valid_in = 1'b1;
    @(negedge div_clk);
    valid_in = 1'b0;
    edges = 1;
    ready_low = 0;
    while (valid_out !== 1'b1 && edges < 100) begin
      if (ready === 1'b0) ready_low++;
      @(negedge div_clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    div_rst_n = 1'b0;
    valid_in = 1'b0;
    in1 = '0;
    in2 = '0;
    is_signed = 1'b0;
    repeat (2) @(negedge div_clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    checks++;
    if (out_q !== 32'h0) begin errors++; $display("FAIL reset_q got %h want 0", out_q); end
    checks++;
    if (out_r !== 32'h0) begin errors++; $display("FAIL reset_r got %h want 0", out_r); end
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    div_rst_n = 1'b1;
    @(negedge div_clk);
  endtask

  task automatic test_unsigned();
    int e, rl;
    issue_and_wait(32'h4bba, 32'h100b, 1'b0, e, rl);
    checks++;
    if (e !== 33) begin errors++; $display("FAIL uns_latency got %0d want 33", e); end
    checks++;
    if (rl !== 32) begin errors++; $display("FAIL uns_ready_low got %0d want 32", rl); end
    checks++;
    if (out_q !== 32'h4) begin errors++; $display("FAIL uns_q got %h want 4", out_q); end
    checks++;
    if (out_r !== 32'hb8e) begin errors++; $display("FAIL uns_r got %h want b8e", out_r); end
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL uns_dbz got %b want 0", div_by_zero); end
    @(negedge div_clk);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL uns_pulse got %b want 0", valid_out); end
    checks++;
    if (out_q !== 32'h4) begin errors++; $display("FAIL uns_hold_q got %h want 4", out_q); end
  endtask

  task automatic test_signedness();
    int e, rl;
    issue_and_wait(32'hffff_fff9, 32'h2, 1'b1, e, rl);
    checks++;
    if (out_q !== 32'hffff_fffd) begin errors++; $display("FAIL sgn_q got %h want fffffffd", out_q); end
    checks++;
    if (out_r !== 32'hffff_ffff) begin errors++; $display("FAIL sgn_r got %h want ffffffff", out_r); end
    @(negedge div_clk);
    issue_and_wait(32'hffff_fff9, 32'h2, 1'b0, e, rl);
    checks++;
    if (out_q !== 32'h7fff_fffc) begin errors++; $display("FAIL usg_q got %h want 7ffffffc", out_q); end
    checks++;
    if (out_r !== 32'h1) begin errors++; $display("FAIL usg_r got %h want 1", out_r); end
    @(negedge div_clk);
  endtask

  task automatic test_div_zero();
    int e, rl;
    for (int s = 0; s < 2; s++) begin
      issue_and_wait(32'h1234, 32'h0, s[0], e, rl);
      checks++;
      if (e !== 1) begin errors++; $display("FAIL dbz_latency s=%0d got %0d want 1", s, e); end
      checks++;
      if (out_q !== 32'hffff_ffff) begin
        errors++; $display("FAIL dbz_q s=%0d got %h want ffffffff", s, out_q);
      end
      checks++;
      if (out_r !== 32'h1234) begin errors++; $display("FAIL dbz_r s=%0d got %h want 1234", s, out_r); end
      checks++;
      if (div_by_zero !== 1'b1) begin
        errors++; $display("FAIL dbz_flag s=%0d got %b want 1", s, div_by_zero);
      end
      @(negedge div_clk);
    end
  endtask

  task automatic test_overflow();
    int e, rl;
    issue_and_wait(32'h8000_0000, 32'hffff_ffff, 1'b1, e, rl);
    checks++;
    if (out_q !== 32'h8000_0000) begin errors++; $display("FAIL ovf_q got %h want 80000000", out_q); end
    checks++;
    if (out_r !== 32'h0) begin errors++; $display("FAIL ovf_r got %h want 0", out_r); end
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz got %b want 0", div_by_zero); end
    @(negedge div_clk);
  endtask

  task automatic test_back_to_back();
    int e, rl, extra;
    // Busy-time strobes carry a zero divisor; accepting one would show as a div_by_zero result.
    in1 = 32'h4bba;
    in2 = 32'h100b;
    is_signed = 1'b0;
    valid_in = 1'b1;
    @(negedge div_clk);
    in1 = 32'h5;
    in2 = 32'h0;
    e = 1;
    while (valid_out !== 1'b1 && e < 100) begin
      valid_in = e[0];
      @(negedge div_clk);
      e++;
    end
    valid_in = 1'b0;
    checks++;
    if (e !== 33) begin errors++; $display("FAIL ign_latency got %0d want 33", e); end
    checks++;
    if (out_q !== 32'h4 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL ign_result got q=%h dbz=%b want q=4 dbz=0", out_q, div_by_zero);
    end
    // Issue the next division in the valid_out cycle.
    issue_and_wait(32'h64, 32'h7, 1'b0, e, rl);
    checks++;
    if (e !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", e); end
    checks++;
    if (out_q !== 32'he) begin errors++; $display("FAIL b2b_q got %h want e", out_q); end
    checks++;
    if (out_r !== 32'h2) begin errors++; $display("FAIL b2b_r got %h want 2", out_r); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge div_clk);
      if (valid_out === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL b2b_extra_valid got %0d want 0", extra); end
    // Held-output check mid-flight of a fresh division.
    in1 = 32'h9;
    in2 = 32'h3;
    valid_in = 1'b1;
    @(negedge div_clk);
    valid_in = 1'b0;
    repeat (5) @(negedge div_clk);
    checks++;
    if (out_q !== 32'he || out_r !== 32'h2) begin
      errors++; $display("FAIL hold_busy got q=%h r=%h want q=e r=2", out_q, out_r);
    end
    repeat (40) @(negedge div_clk);
  endtask

  task automatic test_reset_mid_op();
    int e, rl, seen;
    in1 = 32'h4bba;
    in2 = 32'h100b;
    is_signed = 1'b0;
    valid_in = 1'b1;
    @(negedge div_clk);
    valid_in = 1'b0;
    repeat (9) @(negedge div_clk);
    div_rst_n = 1'b0;
    @(negedge div_clk);
    div_rst_n = 1'b1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", ready); end
    checks++;
    if (out_q !== 32'h0 || out_r !== 32'h0) begin
      errors++; $display("FAIL rst_mid_out got q=%h r=%h want 0 0", out_q, out_r);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_out === 1'b1) seen++;
      @(negedge div_clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_valid got %0d want 0", seen); end
    issue_and_wait(32'h9, 32'h3, 1'b0, e, rl);
    checks++;
    if (out_q !== 32'h3 || out_r !== 32'h0 || e !== 33) begin
      errors++; $display("FAIL rst_after got q=%h r=%h lat=%0d want 3 0 33", out_q, out_r, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signedness();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
